// File: rtl/serial_bit_feeder_if.sv
// Word handshake and serial bit stream of the serial bit feeder.
// The upstream word source uses master; the feeder itself uses slave.
interface serial_bit_feeder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] word_data;
    logic             word_valid;
    logic             word_ready;
    logic             bit_out;
    logic             bit_valid;
    logic             busy;

    modport master (
        output word_data, word_valid,
        input  word_ready, bit_out, bit_valid, busy
    );

    modport slave (
        input  word_data, word_valid,
        output word_ready, bit_out, bit_valid, busy
    );
endinterface

// File: rtl/serial_bit_feeder.sv
// Serializes WIDTH-bit words one bit per clock, then emits a run of zeros so the
// downstream detector restarts at every word boundary. Optional parity bit: SERIAL_BIT_FEEDER_PARITY_EN.
module serial_bit_feeder #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    serial_bit_feeder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

    localparam state_t AFTER_WORD = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [CW-1:0]    bit_cnt_reg;
    logic [3:0]       gap_cnt_reg;
    logic             head_bit;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    logic             parity_reg;
`endif

    // Head of the register is the bit on the wire; the register moves toward it.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
        if (MSB_FIRST != 0) begin : g_msb
            if (gi == 0) begin : g_edge
                assign shift_next[gi] = 1'b0;
            end else begin : g_mid
                assign shift_next[gi] = shift_reg[gi-1];
            end
        end else begin : g_lsb
            if (gi == WIDTH - 1) begin : g_edge
                assign shift_next[gi] = 1'b0;
            end else begin : g_mid
                assign shift_next[gi] = shift_reg[gi+1];
            end
        end
    end

    assign head_bit = (MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.word_valid) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_reg == LAST_BIT) begin
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = AFTER_WORD;
`endif
                end
            end
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
            S_PARITY: state_next = AFTER_WORD;
`endif
            S_GAP: begin
                if (gap_cnt_reg == 4'd0) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            if (state_reg == S_IDLE && bus.word_valid) begin
                shift_reg   <= bus.word_data;
                bit_cnt_reg <= '0;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
                parity_reg  <= ^bus.word_data;
`endif
            end else if (state_reg == S_SHIFT) begin
                shift_reg <= shift_next;
                if (bit_cnt_reg != LAST_BIT) begin
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
            end
            if (state_next == S_GAP && state_reg != S_GAP) begin
                gap_cnt_reg <= GAP_LOAD;
            end else if (state_reg == S_GAP && gap_cnt_reg != 4'd0) begin
                gap_cnt_reg <= gap_cnt_reg - 1'b1;
            end
        end
    end

    always_comb begin
        bus.word_ready = (state_reg == S_IDLE);
        bus.busy       = (state_reg != S_IDLE);
        bus.bit_out    = 1'b0;
        bus.bit_valid  = 1'b0;
        case (state_reg)
            S_SHIFT: begin
                bus.bit_out   = head_bit;
                bus.bit_valid = 1'b1;
            end
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
            S_PARITY: begin
                bus.bit_out   = parity_reg;
                bus.bit_valid = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial source stage that feeds the single-bit `in` input of the downstream sequence-detector FSM. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock. Between words it inserts a programmable run of zero bits so the detector returns to its initial state at every word boundary. It also raises a per-bit strobe so debug logic can align detector output with the source bit.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first, 0 = bit 0 first.
- GAP_CYCLES, 2, zero bits inserted after each word; legal range 0..15.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- word_data  input  WIDTH  parallel word to serialize.
- word_valid  input  1  word_data is valid.
- word_ready  output  1  block can accept a word this cycle.
- bit_out  output  1  serial bit; connects to the downstream detector's `in`.
- bit_valid  output  1  bit_out carries a data (or parity) bit, not an idle/gap zero.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, SHIFT, PARITY (only when the macro is defined), GAP.
- IDLE:
  - word_ready=1, bit_out=0, bit_valid=0.
  - On word_valid&&word_ready: capture word_data into the shift register, clear the bit counter, go to SHIFT.
- SHIFT:
  - bit_out = current head bit (MSB or LSB per MSB_FIRST), bit_valid=1.
  - Shift and increment the counter every cycle.
  - After the WIDTH-th bit, go to PARITY if enabled. Otherwise go to GAP if GAP_CYCLES>0, else IDLE.
- PARITY: bit_out = XOR of the captured word (even parity), bit_valid=1, one cycle. Then go to GAP or IDLE as above.
- GAP:
  - bit_out=0, bit_valid=0 for exactly GAP_CYCLES cycles, then IDLE.
  - The gap counter is 4 bits and loads GAP_CYCLES-1 on entry.
- word_ready is 0 in SHIFT, PARITY and GAP. The word_valid/word_data value seen in those states is ignored, and the upstream must hold it.
- The captured word is a private copy; changes on word_data after acceptance have no effect.
- The bit counter is $clog2(WIDTH) bits and never wraps past WIDTH-1.

## Timing
- Reset values: word_ready=1, bit_out=0, bit_valid=0, busy=0; state=IDLE; shift register and counters cleared.
- Reset asserted mid-word: on the next edge the block is in IDLE with reset values, and the partial word is discarded. No further bits are emitted.
- Word accepted at edge t (P=1 with parity, else 0):
  - First bit is on bit_out in cycle t+1.
  - Last data bit is in cycle t+WIDTH; parity bit, if enabled, in cycle t+WIDTH+1.
  - Gap zeros occupy cycles t+WIDTH+P+1 .. t+WIDTH+P+GAP_CYCLES.
  - word_ready returns high in cycle t+WIDTH+P+GAP_CYCLES+1.
- Throughput: one word per WIDTH+P+GAP_CYCLES+1 cycles, with one mandatory IDLE cycle between words.
- word_valid arriving in the same cycle word_ready rises is accepted at that edge.
- No combinational path from word_valid to word_ready or bit_out. All outputs are registered or decoded from state alone.

## Configuration
- Macro SERIAL_BIT_FEEDER_PARITY_EN.
  - Defined: the PARITY state exists and one even-parity bit, with bit_valid=1, follows every word.
  - Undefined: no PARITY state and P=0. SHIFT goes directly to GAP or IDLE.

## Test plan
- Reset, then idle 5 cycles, with WIDTH=8, MSB_FIRST=1, GAP_CYCLES=2 (Tests 1–3 and 5) -> word_ready=1, bit_out=0, bit_valid=0, busy=0 throughout.
- Send 8'hB4 with macro undefined -> bit_out sequence 1,0,1,1,0,1,0,0 in cycles t+1..t+8 with bit_valid=1. Then 0,0 with bit_valid=0 in t+9..t+10, and word_ready=1 at t+11.
- Send 8'hE0 (three leading ones) into the feeder connected to the detector -> detector output high exactly one cycle, at t+3. Detector output is 0 during the gap, and the detector is in its initial state before the next word.
- Send 8'hB4 with MSB_FIRST=0 and the macro defined -> bits 0,0,1,0,1,1,0,1, then parity bit 0 at t+9 with bit_valid=1, and word_ready=1 at t+12.
- Assert rst at t+4 while sending 8'hFF -> at t+5 state=IDLE, bit_out=0, word_ready=1. No further ones are emitted.
- With GAP_CYCLES=0 and word_valid held high for two words -> words are separated by exactly one IDLE cycle with bit_out=0, and the second word's first bit appears at t+10.
